// File: rtl/sr_latch_exerciser.sv
// sr_latch_exerciser: drives alternating set/reset pulses into an asynchronous
// SR latch and checks the held Q/Qbar after each pulse.
//
// Start handshake: start is a level request sampled only while IDLE. It is
// accepted on the edge where the FSM sits in IDLE and start=1. It is ignored
// while busy and during the DONE cycle. A start held high across DONE
// therefore begins the next run after exactly one IDLE cycle.
module sr_latch_exerciser #(
  parameter int SET_W    = 10,
  parameter int RST_W    = 5,
  parameter int GAP      = 4,
  parameter int NUM_ITER = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             set_o,
  output logic             reset_o,
  input  logic             q_i,
  input  logic             qbar_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       iter_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_P  = 3'd1,
    HOLD_S = 3'd2,
    RST_P  = 3'd3,
    HOLD_R = 3'd4,
    DONE   = 3'd5
  } state_t;

  // One phase counter serves every timed state, so it is sized for the longest.
  localparam int MAX_W = (SET_W > RST_W) ? ((SET_W > GAP) ? SET_W : GAP)
                                         : ((RST_W > GAP) ? RST_W : GAP);
  localparam int CNT_W = (MAX_W > 2) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SET_W - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [7:0]       ITER_TOTAL = 8'(NUM_ITER);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [ERR_W-1:0] err_inc;
  logic [7:0]       iter_nxt;
  logic             pass_nxt;

  logic q_s1;
  logic q_s2;
  logic qbar_s1;
  logic qbar_s2;
  logic set_ok;
  logic rst_ok;

  // Two-flop synchronizers for the latch outputs, which are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1    <= 1'b0;
      q_s2    <= 1'b0;
      qbar_s1 <= 1'b0;
      qbar_s2 <= 1'b0;
    end else begin
      q_s1    <= q_i;
      q_s2    <= q_s1;
      qbar_s1 <= qbar_i;
      qbar_s2 <= qbar_s1;
    end
  end

  // q==qbar (illegal or metastable) fails both checks; each check adds at most one.
  assign set_ok  = q_s2 & ~qbar_s2;
  assign rst_ok  = ~q_s2 & qbar_s2;
  assign err_inc = (err_count == ERR_MAX) ? err_count : err_count + ERR_W'(1);

  // Next-state, phase timing, error and iteration bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_count;
    iter_nxt  = iter_count;
    pass_nxt  = pass;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SET_P;
          cnt_nxt   = '0;
          err_nxt   = '0;
          iter_nxt  = '0;
          pass_nxt  = 1'b0;
        end
      end
      SET_P: begin
        if (cnt == SET_LAST) begin
          state_nxt = HOLD_S;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD_S: begin
        if (cnt == GAP_LAST) begin
          state_nxt = RST_P;
          cnt_nxt   = '0;
          if (!set_ok) err_nxt = err_inc;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RST_P: begin
        if (cnt == RST_LAST) begin
          state_nxt = HOLD_R;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD_R: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt  = '0;
          if (!rst_ok) err_nxt = err_inc;
          iter_nxt  = iter_count + 8'd1;
          state_nxt = (iter_nxt == ITER_TOTAL) ? DONE : SET_P;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The verdict includes any mismatch found by the final reset check.
    if (state_nxt == DONE) pass_nxt = (err_nxt == '0);
  end

  // State and registered outputs; drives decode from the next state so they
  // are flop outputs aligned with their state and can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      err_count  <= '0;
      iter_count <= '0;
      pass       <= 1'b0;
      set_o      <= 1'b0;
      reset_o    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      err_count  <= err_nxt;
      iter_count <= iter_nxt;
      pass       <= pass_nxt;
      set_o      <= (state_nxt == SET_P);
      reset_o    <= (state_nxt == RST_P);
      busy       <= (state_nxt == SET_P) || (state_nxt == HOLD_S) ||
                    (state_nxt == RST_P) || (state_nxt == HOLD_R);
      done       <= (state_nxt == DONE);
    end
  end

endmodule
